id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter REG_W, default 5, register-index width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 readData1D, readData2D  in  DATA_W each  register-file read ports for rsD/rtD.
REQ-006 rsD, rtD, rdD  in  REG_W each  decoded source/destination indices.
REQ-007 immD, pcD  in  DATA_W each  sign-extended immediate; instruction PC.
REQ-008 validD  in  1  ID holds a real instruction.
REQ-009 RegWriteD, MemtoRegD, MemReadD, MemWriteD, ALUSrcD, WrRegDataD  in  1 each  decoded controls.
REQ-010 RegDstD  in  2  write-dest select (00 $ra, 01 rt, 10 rd); ALUOpD  in  4  ALU operation.
REQ-011 flushE  in  1  branch/jump redirect; kill instruction entering EX.
REQ-012 wbWrite  in  1; wbReg  in  REG_W; wbData  in  DATA_W  write-back port driven to the register file this cycle.
REQ-013 rsE, rtE, rdE  out  REG_W; dataAE, dataBE, immE, pcE  out  DATA_W; all D controls mirrored as ...E outputs; validE  out  1.
REQ-014 stallD  out  1  combinational; freezes PC and IF/ID when high.
REQ-015 stallCount  out  32  saturating count of load-use stall cycles.

Function
REQ-016 Load-use: stallD SHALL be 1 iff validE & MemReadE & rtE!=0 & validD & (rtE==rsD | rtE==rtD); else 0.
REQ-017 Update priority per posedge SHALL be: flushE > stallD > normal load.
REQ-018 Normal load SHALL capture all D inputs into E registers, validE=validD, latency exactly one cycle.
REQ-019 Flush or stall SHALL load a bubble: validE=0, every control output 0, RegDstE=00, ALUOpE=0, data/index outputs 0.
REQ-020 Flush and stall simultaneous SHALL produce a single bubble; stallD still reflects REQ-016 combinationally.
REQ-021 WB bypass: on normal load, dataAE SHALL take wbData when wbWrite & wbReg!=0 & wbReg==rsD, else readData1D; same for dataBE with rtD.
REQ-022 Bypass SHALL cover the register file's posedge-write/same-cycle-read gap; register 0 never bypassed, always reads via readData.
REQ-023 Bypass SHALL apply to rs and rt independently; both may match the same wbReg.
REQ-024 stallCount SHALL increment by 1 on each posedge where stallD=1 and flushE=0, saturating at 0xFFFFFFFF (no wrap).
REQ-025 Consecutive load-use stalls SHALL be impossible to self-sustain: the bubble clears MemReadE, so stallD drops the following cycle.
REQ-026 Outputs SHALL be pure registers except stallD.

Reset
REQ-027 Assertion of reset SHALL asynchronously force all E outputs to bubble values (REQ-019) and stallCount=0.
REQ-028 Reset mid-operation SHALL discard the in-flight EX instruction; first posedge after deassertion performs normal load.
REQ-029 During reset stallD SHALL be 0 (validE=0).

Structure
REQ-030 RegDst encodings, ALUOp codes and bubble control value SHALL live in shared package cpu_pkg.
REQ-031 Hazard detect + bypass mux SHALL be one sub-module hazard_bypass (combinational); id_ex_reg holds registers and counter.

Verification
REQ-032 lw $5 in EX (MemReadE=1, rtE=5, validE=1), ID add rsD=5 -> stallD=1, next cycle validE=0, stallCount=1, add loads the cycle after.
REQ-033 Same as REQ-032 with rtE=0 -> stallD=0, no bubble.
REQ-034 wbWrite=1, wbReg=7, wbData=0xDEADBEEF, rsD=rtD=7, readData=0x0 -> dataAE=dataBE=0xDEADBEEF next cycle.
REQ-035 wbReg=0, wbWrite=1, rsD=0, readData1D=0 -> dataAE=0.
REQ-036 flushE=1 with load-use stall active -> one bubble, stallCount unchanged.
REQ-037 Assert reset mid-cycle with validE=1 -> validE=0 immediately, no clock edge needed; preload stallCount=0xFFFFFFFF via forced stalls -> stays saturated.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline encodings: write-destination selects, ALU operation codes
// and the packed control bundle carried from ID into EX.
package cpu_pkg;

    localparam logic [1:0] REGDST_RA = 2'b00;
    localparam logic [1:0] REGDST_RT = 2'b01;
    localparam logic [1:0] REGDST_RD = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic       regWrite;
        logic       memtoReg;
        logic       memRead;
        logic       memWrite;
        logic       aluSrc;
        logic       wrRegData;
        logic [1:0] regDst;
        logic [3:0] aluOp;
    } ctrl_t;

    // A bubble writes nothing, touches no memory and selects the default ALU op.
    localparam ctrl_t CTRL_BUBBLE = '{
        regWrite:  1'b0,
        memtoReg:  1'b0,
        memRead:   1'b0,
        memWrite:  1'b0,
        aluSrc:    1'b0,
        wrRegData: 1'b0,
        regDst:    REGDST_RA,
        aluOp:     ALU_ADD
    };

endpackage

// File: rtl/hazard_bypass.sv
// Load-use hazard detection and write-back bypass selection for the operands
// entering EX; purely combinational.
module hazard_bypass #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              validE,
    input  logic              memReadE,
    input  logic [REG_W-1:0]  rtE,
    input  logic              validD,
    input  logic [REG_W-1:0]  rsD,
    input  logic [REG_W-1:0]  rtD,
    input  logic [DATA_W-1:0] readData1D,
    input  logic [DATA_W-1:0] readData2D,
    input  logic              wbWrite,
    input  logic [REG_W-1:0]  wbReg,
    input  logic [DATA_W-1:0] wbData,
    output logic              stallD,
    output logic [DATA_W-1:0] dataA,
    output logic [DATA_W-1:0] dataB
);

    logic wbLive;

    // Register 0 is hardwired, so a write-back to it never needs forwarding.
    assign wbLive = wbWrite && (wbReg != '0);

    assign stallD = validE && memReadE && (rtE != '0) && validD &&
                    ((rtE == rsD) || (rtE == rtD));

    assign dataA = (wbLive && (wbReg == rsD)) ? wbData : readData1D;
    assign dataB = (wbLive && (wbReg == rtD)) ? wbData : readData2D;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures the decoded instruction, inserts bubbles
// on flush or load-use stall, and counts load-use stall cycles.
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] readData1D,
    input  logic [DATA_W-1:0] readData2D,
    input  logic [REG_W-1:0]  rsD,
    input  logic [REG_W-1:0]  rtD,
    input  logic [REG_W-1:0]  rdD,
    input  logic [DATA_W-1:0] immD,
    input  logic [DATA_W-1:0] pcD,
    input  logic              validD,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              MemReadD,
    input  logic              MemWriteD,
    input  logic              ALUSrcD,
    input  logic              WrRegDataD,
    input  logic [1:0]        RegDstD,
    input  logic [3:0]        ALUOpD,
    input  logic              flushE,
    input  logic              wbWrite,
    input  logic [REG_W-1:0]  wbReg,
    input  logic [DATA_W-1:0] wbData,
    output logic [REG_W-1:0]  rsE,
    output logic [REG_W-1:0]  rtE,
    output logic [REG_W-1:0]  rdE,
    output logic [DATA_W-1:0] dataAE,
    output logic [DATA_W-1:0] dataBE,
    output logic [DATA_W-1:0] immE,
    output logic [DATA_W-1:0] pcE,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              MemReadE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic              WrRegDataE,
    output logic [1:0]        RegDstE,
    output logic [3:0]        ALUOpE,
    output logic              validE,
    output logic              stallD,
    output logic [31:0]       stallCount
);

    import cpu_pkg::*;

    ctrl_t             ctrlD;
    ctrl_t             ctrlE;
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;

    assign ctrlD = {RegWriteD, MemtoRegD, MemReadD, MemWriteD, ALUSrcD,
                    WrRegDataD, RegDstD, ALUOpD};

    assign {RegWriteE, MemtoRegE, MemReadE, MemWriteE, ALUSrcE,
            WrRegDataE, RegDstE, ALUOpE} = ctrlE;

    hazard_bypass #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_hazard_bypass (
        .validE     (validE),
        .memReadE   (ctrlE.memRead),
        .rtE        (rtE),
        .validD     (validD),
        .rsD        (rsD),
        .rtD        (rtD),
        .readData1D (readData1D),
        .readData2D (readData2D),
        .wbWrite    (wbWrite),
        .wbReg      (wbReg),
        .wbData     (wbData),
        .stallD     (stallD),
        .dataA      (dataA),
        .dataB      (dataB)
    );

    // Flush outranks stall; either one turns the EX slot into a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validE <= 1'b0;
            ctrlE  <= CTRL_BUBBLE;
            rsE    <= '0;
            rtE    <= '0;
            rdE    <= '0;
            dataAE <= '0;
            dataBE <= '0;
            immE   <= '0;
            pcE    <= '0;
        end else if (flushE || stallD) begin
            validE <= 1'b0;
            ctrlE  <= CTRL_BUBBLE;
            rsE    <= '0;
            rtE    <= '0;
            rdE    <= '0;
            dataAE <= '0;
            dataBE <= '0;
            immE   <= '0;
            pcE    <= '0;
        end else begin
            validE <= validD;
            ctrlE  <= ctrlD;
            rsE    <= rsD;
            rtE    <= rtD;
            rdE    <= rdD;
            dataAE <= dataA;
            dataBE <= dataB;
            immE   <= immD;
            pcE    <= pcD;
        end
    end

    // A flushed stall cycle is not counted: the redirect wins that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCount <= '0;
        end else if (stallD && !flushE && (stallCount != 32'hFFFF_FFFF)) begin
            stallCount <= stallCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: a register-file-level reference model
// predicts each EX load, and a monitor compares the DUT against a queue.
module tb_id_ex_reg;

    localparam logic [11:0] CTRL_LW  = 12'b1110_1001_0000;
    localparam logic [11:0] CTRL_ADD = 12'b1000_0010_0000;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] dataA;
        logic [31:0] dataB;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [11:0] ctrl;
    } eState_t;

    typedef struct packed {
        logic        stall;
        eState_t     e;
        logic [31:0] count;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] readData1D, readData2D, immD, pcD, wbData;
    logic [4:0]  rsD, rtD, rdD, wbReg;
    logic        validD, flushE, wbWrite;
    logic        RegWriteD, MemtoRegD, MemReadD, MemWriteD, ALUSrcD, WrRegDataD;
    logic [1:0]  RegDstD;
    logic [3:0]  ALUOpD;
    logic [4:0]  rsE, rtE, rdE;
    logic [31:0] dataAE, dataBE, immE, pcE, stallCount;
    logic        RegWriteE, MemtoRegE, MemReadE, MemWriteE, ALUSrcE, WrRegDataE;
    logic [1:0]  RegDstE;
    logic [3:0]  ALUOpE;
    logic        validE, stallD;

    exp_t        expQ[$];
    eState_t     mE;
    logic [31:0] mCount;
    logic [31:0] regs[32];
    int          checkCount = 0;
    int          passCount  = 0;
    logic        sampledStall;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .reset(reset),
        .readData1D(readData1D), .readData2D(readData2D),
        .rsD(rsD), .rtD(rtD), .rdD(rdD), .immD(immD), .pcD(pcD),
        .validD(validD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemReadD(MemReadD),
        .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .WrRegDataD(WrRegDataD),
        .RegDstD(RegDstD), .ALUOpD(ALUOpD),
        .flushE(flushE), .wbWrite(wbWrite), .wbReg(wbReg), .wbData(wbData),
        .rsE(rsE), .rtE(rtE), .rdE(rdE),
        .dataAE(dataAE), .dataBE(dataBE), .immE(immE), .pcE(pcE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemReadE(MemReadE),
        .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .WrRegDataE(WrRegDataE),
        .RegDstE(RegDstE), .ALUOpE(ALUOpE),
        .validE(validE), .stallD(stallD), .stallCount(stallCount)
    );

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One ID-stage cycle: drive inputs, predict the EX contents after the edge.
    task automatic applyStimulus(input logic dValid, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [11:0] ctrl,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic flush, input logic wbW, input logic [4:0] wbR,
                                 input logic [31:0] wbD);
        logic [31:0] arch[32];
        exp_t        ex;
        @(negedge clk);
        validD = dValid; rsD = rs; rtD = rt; rdD = rd; immD = imm; pcD = pc;
        {RegWriteD, MemtoRegD, MemReadD, MemWriteD, ALUSrcD, WrRegDataD, RegDstD, ALUOpD} = ctrl;
        flushE = flush; wbWrite = wbW; wbReg = wbR; wbData = wbD;
        readData1D = regs[rs];
        readData2D = regs[rt];
        #1;
        arch = regs;
        if (wbW && wbR != 5'd0) arch[wbR] = wbD;
        ex.stall = mE.valid && mE.ctrl[9] && (mE.rt != 5'd0) && dValid &&
                   ((mE.rt == rs) || (mE.rt == rt));
        if (flush || ex.stall) begin
            ex.e = '0;
        end else begin
            ex.e.valid = dValid; ex.e.rs = rs; ex.e.rt = rt; ex.e.rd = rd;
            ex.e.dataA = arch[rs]; ex.e.dataB = arch[rt];
            ex.e.imm = imm; ex.e.pc = pc; ex.e.ctrl = ctrl;
        end
        if (ex.stall && !flush && mCount != 32'hFFFF_FFFF) mCount = mCount + 32'd1;
        ex.count = mCount;
        mE = ex.e;
        regs = arch;
        expQ.push_back(ex);
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("reset_validE", {95'd0, validE}, 96'd0);
        checkOutput("reset_stallD", {95'd0, stallD}, 96'd0);
        checkOutput("reset_count", {64'd0, stallCount}, 96'd0);
        checkOutput("reset_ctrl", {84'd0, RegWriteE, MemtoRegE, MemReadE, MemWriteE,
                                   ALUSrcE, WrRegDataE, RegDstE, ALUOpE}, 96'd0);
        mE = '0;
        mCount = 32'd0;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    // Monitor: stallD sampled mid-low-phase, registers sampled just after the edge.
    initial begin
        exp_t ex;
        forever begin
            @(negedge clk);
            #3 sampledStall = stallD;
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                ex = expQ.pop_front();
                checkOutput("stallD", {95'd0, sampledStall}, {95'd0, ex.stall});
                checkOutput("validE", {95'd0, validE}, {95'd0, ex.e.valid});
                checkOutput("idx", {81'd0, rsE, rtE, rdE}, {81'd0, ex.e.rs, ex.e.rt, ex.e.rd});
                checkOutput("dataAE", {64'd0, dataAE}, {64'd0, ex.e.dataA});
                checkOutput("dataBE", {64'd0, dataBE}, {64'd0, ex.e.dataB});
                checkOutput("imm_pc", {32'd0, immE, pcE}, {32'd0, ex.e.imm, ex.e.pc});
                checkOutput("ctrl", {84'd0, RegWriteE, MemtoRegE, MemReadE, MemWriteE,
                                     ALUSrcE, WrRegDataE, RegDstE, ALUOpE}, {84'd0, ex.e.ctrl});
                checkOutput("stallCount", {64'd0, stallCount}, {64'd0, ex.count});
            end
        end
    end

    initial begin
        logic [11:0] c;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        mE = '0; mCount = 32'd0;
        reset = 1'b1;
        validD = 0; rsD = 0; rtD = 0; rdD = 0; immD = 0; pcD = 0;
        {RegWriteD, MemtoRegD, MemReadD, MemWriteD, ALUSrcD, WrRegDataD, RegDstD, ALUOpD} = 12'd0;
        flushE = 0; wbWrite = 0; wbReg = 0; wbData = 0; readData1D = 0; readData2D = 0;
        #3;
        checkOutput("por_validE", {95'd0, validE}, 96'd0);
        checkOutput("por_count", {64'd0, stallCount}, 96'd0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Load-use on $5: one bubble, counted, then the add loads.
        applyStimulus(1, 5'd1, 5'd5, 5'd0, CTRL_LW, 32'h10, 32'h100, 0, 0, 5'd0, 32'd0);
        applyStimulus(1, 5'd5, 5'd2, 5'd3, CTRL_ADD, 32'h0, 32'h104, 0, 0, 5'd0, 32'd0);
        applyStimulus(1, 5'd5, 5'd2, 5'd3, CTRL_ADD, 32'h0, 32'h104, 0, 0, 5'd0, 32'd0);
        // Load into $0 never stalls.
        applyStimulus(1, 5'd1, 5'd0, 5'd0, CTRL_LW, 32'h20, 32'h108, 0, 0, 5'd0, 32'd0);
        applyStimulus(1, 5'd0, 5'd0, 5'd4, CTRL_ADD, 32'h0, 32'h10C, 0, 0, 5'd0, 32'd0);
        // Same-cycle write-back bypass on both operands, and none for $0.
        applyStimulus(1, 5'd7, 5'd7, 5'd8, CTRL_ADD, 32'h0, 32'h110, 0, 1, 5'd7, 32'hDEAD_BEEF);
        applyStimulus(1, 5'd0, 5'd0, 5'd9, CTRL_ADD, 32'h0, 32'h114, 0, 1, 5'd0, 32'h1234_5678);
        // Flush during an active load-use stall: one bubble, no count.
        applyStimulus(1, 5'd2, 5'd6, 5'd0, CTRL_LW, 32'h4, 32'h118, 0, 0, 5'd0, 32'd0);
        applyStimulus(1, 5'd6, 5'd1, 5'd2, CTRL_ADD, 32'h0, 32'h11C, 1, 0, 5'd0, 32'd0);

        for (int i = 0; i < 400; i++) begin
            c = 12'($urandom);
            c[9] = ($urandom_range(0, 9) < 4);
            applyStimulus(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), c,
                          $urandom, $urandom, ($urandom_range(0, 9) == 0),
                          1'($urandom), 5'($urandom_range(0, 7)), $urandom);
        end

        // Saturation: preload the counter just below the limit.
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 12'd0, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        @(posedge clk);
        #2 force dut.stallCount = 32'hFFFF_FFFE;
        #1 release dut.stallCount;
        mCount = 32'hFFFF_FFFE;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 5'd1, 5'd5, 5'd0, CTRL_LW, 32'h0, 32'h200, 0, 0, 5'd0, 32'd0);
            applyStimulus(1, 5'd3, 5'd5, 5'd6, CTRL_ADD, 32'h0, 32'h204, 0, 0, 5'd0, 32'd0);
            applyStimulus(1, 5'd3, 5'd5, 5'd6, CTRL_ADD, 32'h0, 32'h204, 0, 0, 5'd0, 32'd0);
        end

        // Reset with a live load in EX, then normal operation resumes.
        applyStimulus(1, 5'd1, 5'd4, 5'd0, CTRL_LW, 32'h8, 32'h300, 0, 0, 5'd0, 32'd0);
        resetPulse();
        applyStimulus(1, 5'd4, 5'd2, 5'd3, CTRL_ADD, 32'h0, 32'h304, 0, 0, 5'd0, 32'd0);
        applyStimulus(1, 5'd2, 5'd3, 5'd1, CTRL_ADD, 32'h0, 32'h308, 0, 1, 5'd2, 32'hCAFE_F00D);

        @(posedge clk);
        #3;
        checkOutput("queue_drained", 96'(expQ.size()), 96'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
